// File: rtl/vga_scan_gen.sv
// Parametrised VGA timing and scaled framebuffer address generator running on the system clock.
// Optional vblank interrupt flag enabled by defining VGA_VBLANK_IRQ_EN.
module vga_scan_gen #(
   parameter int          H_ACTIVE    = 640,
   parameter int          H_FP        = 16,
   parameter int          H_SYNC      = 96,
   parameter int          H_BP        = 48,
   parameter int          V_ACTIVE    = 480,
   parameter int          V_FP        = 10,
   parameter int          V_SYNC      = 2,
   parameter int          V_BP        = 33,
   parameter int          CLK_DIV     = 2,
   parameter int          SCALE_SHIFT = 3,
   parameter int          ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 'h200,
   parameter int          RD_LATENCY  = 1,
   parameter bit          SYNC_POL    = 1'b0
) (
   input  logic                                            clk,
   input  logic                                            reset,
   output logic                                            pix_tick,
   output logic                                            hsync,
   output logic                                            vsync,
   output logic                                            disp_active,
   output logic [ADDR_W-1:0]                               fb_addr,
   output logic                                            line_start,
   output logic                                            frame_start,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]    h_count,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]    v_count,
   output logic                                            vblank_irq,
   input  logic                                            irq_ack
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0]     DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [VW-1:0]     V_ROW_MASK = VW'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_W-1:0] FB_COLS    = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

   logic [DW-1:0]     r_div_cnt;
   logic [HW-1:0]     r_h_cnt;
   logic [VW-1:0]     r_v_cnt;
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_fb_addr;
   // Each stage holds {active, hsync_raw, vsync_raw}.
   logic [2:0]        r_pipe [RD_LATENCY+1];

   logic              w_tick;
   logic              w_h_wrap;
   logic              w_frame_wrap;
   logic              w_active;
   logic              w_hs_raw;
   logic              w_vs_raw;
   logic              w_row_step;
   logic [ADDR_W-1:0] w_pix_addr;
   logic [2:0]        w_pipe_out;

   assign w_tick       = ~reset & (r_div_cnt == DIV_LAST);
   assign w_h_wrap     = w_tick & (r_h_cnt == H_LAST);
   assign w_frame_wrap = w_h_wrap & (r_v_cnt == V_LAST);
   assign w_active     = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
   assign w_hs_raw     = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt <= H_SYNC_END);
   assign w_vs_raw     = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt <= V_SYNC_END);
   // Last screen line of a framebuffer row: advance to the next row on this wrap.
   assign w_row_step   = (r_v_cnt < V_ACT_END) && ((r_v_cnt & V_ROW_MASK) == V_ROW_MASK);
   assign w_pix_addr   = BASE_ADDR + r_row_base + ADDR_W'(r_h_cnt >> SCALE_SHIFT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt <= '0;
      end else if (r_div_cnt == DIV_LAST) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt    <= '0;
         r_v_cnt    <= '0;
         r_row_base <= '0;
         r_fb_addr  <= BASE_ADDR;
      end else if (w_tick) begin
         r_fb_addr <= w_active ? w_pix_addr : BASE_ADDR;
         if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            if (w_frame_wrap) begin
               r_row_base <= '0;
            end else if (w_row_step) begin
               r_row_base <= r_row_base + FB_COLS;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
      end
   end

   // NOTE: this array is a handful of flops, not RAM, so it is reset to give clean sync levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i <= RD_LATENCY; i++) begin
            r_pipe[i] <= '0;
         end
      end else if (w_tick) begin
         r_pipe[0] <= {w_active, w_hs_raw, w_vs_raw};
         for (int i = 1; i <= RD_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign w_pipe_out  = r_pipe[RD_LATENCY];
   assign disp_active = w_pipe_out[2];
   assign hsync       = w_pipe_out[1] ? SYNC_POL : ~SYNC_POL;
   assign vsync       = w_pipe_out[0] ? SYNC_POL : ~SYNC_POL;
   assign fb_addr     = r_fb_addr;
   assign pix_tick    = w_tick;
   assign line_start  = w_h_wrap;
   assign frame_start = w_frame_wrap;
   assign h_count     = r_h_cnt;
   assign v_count     = r_v_cnt;

`ifdef VGA_VBLANK_IRQ_EN
   localparam logic [VW-1:0] V_IRQ_LINE = VW'(V_ACTIVE - 1);

   logic r_vblank_irq;
   logic w_vblank_set;

   assign w_vblank_set = w_h_wrap & (r_v_cnt == V_IRQ_LINE);

   // Set has priority so an ack racing the new vblank cannot lose it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vblank_irq <= 1'b0;
      end else if (w_vblank_set) begin
         r_vblank_irq <= 1'b1;
      end else if (irq_ack) begin
         r_vblank_irq <= 1'b0;
      end
   end

   assign vblank_irq = r_vblank_irq;
`else
   logic w_unused_irq_ack;

   assign w_unused_irq_ack = irq_ack;
   assign vblank_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default timing, a tiny screen, and a short-frame latency-2 variant.
// Follows VGA_VBLANK_IRQ_EN the same way as the design.
module tb_vga_scan_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // ---------------- default configuration ----------------
   logic        df_reset = 1'b1, df_irq_ack = 1'b0;
   logic        df_tick, df_hs, df_vs, df_disp, df_ls, df_fs, df_irq;
   logic [31:0] df_fb;
   logic [9:0]  df_h, df_v;

   vga_scan_gen u_df (
      .clk(clk), .reset(df_reset), .pix_tick(df_tick), .hsync(df_hs), .vsync(df_vs),
      .disp_active(df_disp), .fb_addr(df_fb), .line_start(df_ls), .frame_start(df_fs),
      .h_count(df_h), .v_count(df_v), .vblank_irq(df_irq), .irq_ack(df_irq_ack)
   );

   // ---------------- tiny screen ----------------
   logic        sm_reset = 1'b1, sm_irq_ack = 1'b0;
   logic        sm_tick, sm_hs, sm_vs, sm_disp, sm_ls, sm_fs, sm_irq;
   logic [31:0] sm_fb;
   logic [3:0]  sm_h;
   logic [2:0]  sm_v;

   vga_scan_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .SCALE_SHIFT(1), .RD_LATENCY(0)
   ) u_sm (
      .clk(clk), .reset(sm_reset), .pix_tick(sm_tick), .hsync(sm_hs), .vsync(sm_vs),
      .disp_active(sm_disp), .fb_addr(sm_fb), .line_start(sm_ls), .frame_start(sm_fs),
      .h_count(sm_h), .v_count(sm_v), .vblank_irq(sm_irq), .irq_ack(sm_irq_ack)
   );

   // ---------------- 800-wide, 22-line frame, latency 2 ----------------
   logic        md_reset = 1'b1, md_irq_ack = 1'b0;
   logic        md_tick, md_hs, md_vs, md_disp, md_ls, md_fs, md_irq;
   logic [31:0] md_fb;
   logic [9:0]  md_h;
   logic [4:0]  md_v;

   vga_scan_gen #(
      .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .CLK_DIV(1), .RD_LATENCY(2)
   ) u_md (
      .clk(clk), .reset(md_reset), .pix_tick(md_tick), .hsync(md_hs), .vsync(md_vs),
      .disp_active(md_disp), .fb_addr(md_fb), .line_start(md_ls), .frame_start(md_fs),
      .h_count(md_h), .v_count(md_v), .vblank_irq(md_irq), .irq_ack(md_irq_ack)
   );

`ifdef VGA_VBLANK_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   initial begin
      int ls_cnt, first_ls, second_ls, ticks_between, df_fs_cnt;
      int first_fs, fs_cnt, pre_fs_cnt;
      logic irq_exp;
      logic [31:0] fb_exp;
      bit act;

      // ======== default configuration ========
      repeat (3) @(negedge clk);
      check("df reset h", df_h, 0);
      check("df reset v", df_v, 0);
      check("df reset fb", df_fb, 32'h200);
      check("df reset hsync", df_hs, 1);
      check("df reset vsync", df_vs, 1);
      check("df reset disp", df_disp, 0);
      check("df reset tick", df_tick, 0);
      check("df reset irq", df_irq, 0);
      df_reset = 1'b0;
      #1;
      ls_cnt = 0; first_ls = -1; second_ls = -1; ticks_between = 0; df_fs_cnt = 0;
      for (int i = 0; i <= 3300; i++) begin
         if (i < 8) begin
            check($sformatf("df tick i%0d", i), df_tick, (i % 2 == 1));
            check($sformatf("df h i%0d", i), df_h, i / 2);
         end
         if (i == 1600) begin
            check("df v after wrap", df_v, 1);
            check("df h after wrap", df_h, 0);
         end
         if (ls_cnt == 1 && df_tick) ticks_between++;
         if (df_ls) begin
            if (ls_cnt == 0) first_ls = i;
            else if (ls_cnt == 1) second_ls = i;
            ls_cnt++;
         end
         if (df_fs) df_fs_cnt++;
         @(negedge clk);
      end
      check("df line_start count", ls_cnt, 2);
      check("df first line_start clk", first_ls, 1599);
      check("df line_start spacing clks", second_ls - first_ls, 1600);
      check("df ticks per line", ticks_between, 800);
      check("df no frame_start", df_fs_cnt, 0);

      // ======== tiny screen: two full frames ========
      check("sm reset h", sm_h, 0);
      check("sm reset v", sm_v, 0);
      check("sm reset fb", sm_fb, 32'h200);
      check("sm reset hsync", sm_hs, 1);
      check("sm reset vsync", sm_vs, 1);
      check("sm reset disp", sm_disp, 0);
      check("sm reset tick gated", sm_tick, 0);
      check("sm reset line_start", sm_ls, 0);
      check("sm reset irq", sm_irq, 0);
      sm_reset = 1'b0;
      #1;
      irq_exp = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int v = 0; v < 7; v++) begin
            for (int h = 0; h < 14; h++) begin
               check($sformatf("sm h f%0d v%0d h%0d", f, v, h), sm_h, h);
               check($sformatf("sm v f%0d v%0d h%0d", f, v, h), sm_v, v);
               check($sformatf("sm tick f%0d v%0d h%0d", f, v, h), sm_tick, 1);
               check($sformatf("sm line_start f%0d v%0d h%0d", f, v, h), sm_ls, (h == 13));
               check($sformatf("sm frame_start f%0d v%0d h%0d", f, v, h), sm_fs, (h == 13 && v == 6));
               if (IRQ_EN)
                  sm_irq_ack = (f == 0 && v == 5 && h == 5) || (f == 1 && v == 3 && h == 13);
               else
                  sm_irq_ack = ~sm_irq_ack;
               @(posedge clk);
               @(negedge clk);
               if (IRQ_EN) begin
                  if (v == 3 && h == 13) irq_exp = 1'b1;
                  else if (sm_irq_ack) irq_exp = 1'b0;
               end
               act = (h < 8) && (v < 4);
               fb_exp = act ? 32'h200 + 32'((v / 2) * 4 + h / 2) : 32'h200;
               check($sformatf("sm fb f%0d v%0d h%0d", f, v, h), sm_fb, fb_exp);
               check($sformatf("sm disp f%0d v%0d h%0d", f, v, h), sm_disp, act);
               check($sformatf("sm hsync f%0d v%0d h%0d", f, v, h), sm_hs, !(h == 10 || h == 11));
               check($sformatf("sm vsync f%0d v%0d h%0d", f, v, h), sm_vs, !(v == 5));
               check($sformatf("sm irq f%0d v%0d h%0d", f, v, h), sm_irq, irq_exp);
            end
         end
      end
      sm_irq_ack = 1'b0;

      // ======== medium: latency 2, then a mid-line reset ========
      check("md reset fb", md_fb, 32'h200);
      check("md reset hsync", md_hs, 1);
      md_reset = 1'b0;
      #1;
      pre_fs_cnt = 0;
      for (int s = 0; s <= 8300; s++) begin
         case (s)
            1:    begin check("md fb s1", md_fb, 32'h200); check("md disp s1", md_disp, 0); end
            2:    check("md disp s2", md_disp, 0);
            3:    check("md disp rise s3", md_disp, 1);
            8:    check("md fb s8", md_fb, 32'h200);
            9:    check("md fb s9", md_fb, 32'h201);
            640:  check("md fb last active", md_fb, 32'h24F);
            641:  check("md fb blank", md_fb, 32'h200);
            642:  check("md disp s642", md_disp, 1);
            643:  check("md disp fall s643", md_disp, 0);
            658:  check("md hsync s658", md_hs, 1);
            659:  check("md hsync s659", md_hs, 0);
            754:  check("md hsync s754", md_hs, 0);
            755:  check("md hsync s755", md_hs, 1);
            5601: check("md fb line7", md_fb, 32'h200);
            6401: check("md fb line8", md_fb, 32'h250);
            6409: check("md fb line8 col1", md_fb, 32'h251);
            8300: begin check("md pre-reset h", md_h, 300); check("md pre-reset v", md_v, 10); end
            default: ;
         endcase
         if (md_fs) pre_fs_cnt++;
         if (s < 8300) @(negedge clk);
      end
      check("md no early frame_start", pre_fs_cnt, 0);

      md_reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("md midreset h", md_h, 0);
      check("md midreset v", md_v, 0);
      check("md midreset fb", md_fb, 32'h200);
      check("md midreset hsync", md_hs, 1);
      check("md midreset vsync", md_vs, 1);
      check("md midreset disp", md_disp, 0);
      check("md midreset frame_start", md_fs, 0);
      md_reset = 1'b0;
      #1;
      first_fs = -1; fs_cnt = 0;
      for (int r = 0; r <= 17600; r++) begin
         md_irq_ack = 1'b0;
         case (r)
            0:     check("md restart tick", md_tick, 1);
            799:   check("md line_start r799", md_ls, 1);
            800:   begin check("md line_start r800", md_ls, 0); check("md v r800", md_v, 1); end
            12799: check("md irq before vblank", md_irq, 0);
            12800: begin check("md irq at v16", md_irq, IRQ_EN); check("md v r12800", md_v, 16); end
            14000: begin check("md irq held", md_irq, IRQ_EN); md_irq_ack = 1'b1; end
            14001: check("md irq acked", md_irq, 0);
            14402: check("md vsync r14402", md_vs, 1);
            14403: check("md vsync r14403", md_vs, 0);
            16002: check("md vsync r16002", md_vs, 0);
            16003: check("md vsync r16003", md_vs, 1);
            17000: check("md irq stays clear", md_irq, 0);
            default: ;
         endcase
         if (md_fs) begin
            if (first_fs < 0) first_fs = r;
            fs_cnt++;
         end
         if (r < 17600) @(negedge clk);
      end
      check("md first frame_start", first_fs, 17599);
      check("md frame_start count", fs_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
